stream_downsizer: RTL and testbench

STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

---
 rtl/stream_downsizer.sv | 104 ++++++++++
 tb/tb_stream_downsizer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsizer.sv
// rtl/stream_downsizer.sv - wide-to-narrow stream width converter, LSB slice first
module stream_downsizer #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  s_in_tdata,
    input  logic                 s_in_tvalid,
    input  logic                 s_in_tlast,
    output logic                 s_in_tready,
    output logic [OUT_WIDTH-1:0] m_out_tdata,
    output logic                 m_out_tvalid,
    output logic                 m_out_tlast,
    input  logic                 m_out_tready
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IN_WIDTH-1:0]  hold_q;
    logic                 last_q;
    logic [IDX_W-1:0]     idx_q;
    logic [OUT_WIDTH-1:0] beats [RATIO];
    logic                 in_fire;
    logic                 out_fire;
    logic                 at_last_idx;

    for (genvar i = 0; i < RATIO; i++) begin : g_beats
        assign beats[i] = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
    end

    assign at_last_idx = (idx_q == LAST_IDX);
    assign in_fire     = s_in_tvalid & s_in_tready;
    assign out_fire    = m_out_tvalid & m_out_tready;
    assign m_out_tdata = beats[idx_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A reload on the final beat keeps us BUSY with no bubble.
                if (out_fire && at_last_idx && !in_fire) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        s_in_tready  = 1'b0;
        m_out_tvalid = 1'b0;
        m_out_tlast  = 1'b0;
        case (state_q)
            EMPTY: begin
                s_in_tready = 1'b1;
            end
            BUSY: begin
                m_out_tvalid = 1'b1;
                m_out_tlast  = last_q & at_last_idx;
                s_in_tready  = at_last_idx & m_out_tready;
            end
            default: begin
                s_in_tready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            last_q <= 1'b0;
            idx_q  <= '0;
        end else if (in_fire) begin
            hold_q <= s_in_tdata;
            last_q <= s_in_tlast;
            idx_q  <= '0;
        end else if (out_fire) begin
            idx_q <= at_last_idx ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// tb/tb_stream_downsizer.sv - scoreboard bench for stream_downsizer
module tb_stream_downsizer;
    localparam int IN_W  = 128;
    localparam int OUT_W = 32;
    localparam int RATIO = IN_W / OUT_W;
    localparam int NWORDS = 4000;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  s_in_tdata;
    logic             s_in_tvalid;
    logic             s_in_tlast;
    logic             s_in_tready;
    logic [OUT_W-1:0] m_out_tdata;
    logic             m_out_tvalid;
    logic             m_out_tlast;
    logic             m_out_tready;

    stream_downsizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_in_tdata   (s_in_tdata),
        .s_in_tvalid  (s_in_tvalid),
        .s_in_tlast   (s_in_tlast),
        .s_in_tready  (s_in_tready),
        .m_out_tdata  (m_out_tdata),
        .m_out_tvalid (m_out_tvalid),
        .m_out_tlast  (m_out_tlast),
        .m_out_tready (m_out_tready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    beat_no = 0;
    int    last_pos[$];

    task automatic chk(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Expected beats: every accepted word expands to RATIO slices, LSB first.
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data;
    logic             prev_last;
    beat_t            mb;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
            chk("rst_tvalid", IN_W'(m_out_tvalid), '0);
            chk("rst_tlast", IN_W'(m_out_tlast), '0);
            chk("rst_tdata", IN_W'(m_out_tdata), '0);
            chk("rst_tready", IN_W'(s_in_tready), IN_W'(1));
        end else begin
            chk("tvalid_model", IN_W'(m_out_tvalid), IN_W'(exp_q.size() != 0));
            chk("tready_model", IN_W'(s_in_tready),
                IN_W'(exp_q.size() == 0 || (exp_q.size() == 1 && m_out_tready)));
            if (!m_out_tvalid) chk("tlast_idle", IN_W'(m_out_tlast), '0);
            if (prev_stall) begin
                chk("stall_valid", IN_W'(m_out_tvalid), IN_W'(1));
                chk("stall_data", IN_W'(m_out_tdata), IN_W'(prev_data));
                chk("stall_last", IN_W'(m_out_tlast), IN_W'(prev_last));
            end
            if (m_out_tvalid && m_out_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", IN_W'(1), '0);
                end else begin
                    mb = exp_q.pop_front();
                    chk("beat_data", IN_W'(m_out_tdata), IN_W'(mb.data));
                    chk("beat_last", IN_W'(m_out_tlast), IN_W'(mb.last));
                end
                beat_no++;
                if (m_out_tlast) last_pos.push_back(beat_no);
            end
            if (s_in_tvalid && s_in_tready) begin
                for (int i = 0; i < RATIO; i++) begin
                    mb.data = s_in_tdata[i*OUT_W +: OUT_W];
                    mb.last = s_in_tlast && (i == RATIO - 1);
                    exp_q.push_back(mb);
                end
            end
            prev_stall = m_out_tvalid && !m_out_tready;
            prev_data  = m_out_tdata;
            prev_last  = m_out_tlast;
        end
    end

    logic [IN_W-1:0]  w;
    logic [IN_W-1:0]  w27;
    logic [OUT_W-1:0] exp27 [4];
    int acc;
    int cyc;

    initial begin
        rst = 1'b1;
        s_in_tvalid = 1'b0;
        s_in_tdata = '0;
        s_in_tlast = 1'b0;
        m_out_tready = 1'b0;
        step();
        step();
        chk("reset_tvalid", IN_W'(m_out_tvalid), '0);
        chk("reset_tdata", IN_W'(m_out_tdata), '0);
        chk("reset_tready", IN_W'(s_in_tready), IN_W'(1));
        rst = 1'b0;
        step();

        // Single word, LSB slice first, tlast on the fourth beat only.
        w27 = 128'h44443333_22221111_11110000_00000000;
        exp27 = '{32'h00000000, 32'h11110000, 32'h22221111, 32'h44443333};
        m_out_tready = 1'b1;
        s_in_tvalid = 1'b1;
        s_in_tdata = w27;
        s_in_tlast = 1'b1;
        #1;
        chk("t27_ready_empty", IN_W'(s_in_tready), IN_W'(1));
        chk("t27_no_valid_yet", IN_W'(m_out_tvalid), '0);
        step();
        s_in_tvalid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t27_valid", IN_W'(m_out_tvalid), IN_W'(1));
            chk("t27_data", IN_W'(m_out_tdata), IN_W'(exp27[i]));
            chk("t27_last", IN_W'(m_out_tlast), IN_W'(i == 3));
            step();
            #1;
        end
        chk("t27_empty", IN_W'(m_out_tvalid), '0);

        // Three back-to-back words: 12 gapless beats, ready only on final beats.
        acc = 0;
        for (int c = 0; c < 14; c++) begin
            s_in_tvalid = (acc < 3);
            s_in_tdata = rand_word();
            s_in_tlast = (acc == 2);
            #1;
            chk("t28_ready", IN_W'(s_in_tready), IN_W'(c == 0 || c % 4 == 0 || c == 13));
            chk("t28_valid", IN_W'(m_out_tvalid), IN_W'(c >= 1 && c <= 12));
            if (s_in_tvalid && s_in_tready) acc++;
            step();
        end
        s_in_tvalid = 1'b0;
        step();

        // Backpressure 1,0,0,1 mid-packet; no input accepted until final beat leaves.
        w = rand_word();
        s_in_tvalid = 1'b1;
        s_in_tdata = w;
        s_in_tlast = 1'b1;
        m_out_tready = 1'b1;
        #1;
        step();
        s_in_tvalid = 1'b0;
        #1;
        chk("t29_slice0", IN_W'(m_out_tdata), IN_W'(w[31:0]));
        step();
        m_out_tready = 1'b0;
        #1;
        chk("t29_slice1", IN_W'(m_out_tdata), IN_W'(w[63:32]));
        step();
        #1;
        chk("t29_freeze", IN_W'(m_out_tdata), IN_W'(w[63:32]));
        step();
        m_out_tready = 1'b1;
        #1;
        chk("t29_slice1_go", IN_W'(m_out_tdata), IN_W'(w[63:32]));
        step();
        #1;
        chk("t29_slice2", IN_W'(m_out_tdata), IN_W'(w[95:64]));
        step();
        m_out_tready = 1'b0;
        s_in_tvalid = 1'b1;
        s_in_tdata = rand_word();
        s_in_tlast = 1'b1;
        #1;
        chk("t29_ready_held_low", IN_W'(s_in_tready), '0);
        chk("t29_slice3", IN_W'(m_out_tdata), IN_W'(w[127:96]));
        step();
        m_out_tready = 1'b1;
        #1;
        chk("t29_ready_final", IN_W'(s_in_tready), IN_W'(1));
        step();
        s_in_tvalid = 1'b0;
        repeat (6) step();

        // Two-word packet: exactly one tlast, on beat 8.
        last_pos.delete();
        beat_no = 0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            s_in_tvalid = (acc < 2);
            s_in_tdata = rand_word();
            s_in_tlast = (acc == 1);
            #1;
            if (s_in_tvalid && s_in_tready) acc++;
            step();
        end
        s_in_tvalid = 1'b0;
        chk("t30_tlast_count", IN_W'(last_pos.size()), IN_W'(1));
        if (last_pos.size() > 0) chk("t30_tlast_pos", IN_W'(last_pos[0]), IN_W'(8));

        // Asynchronous reset at idx 2, then a fresh word starts at slice 0.
        s_in_tvalid = 1'b1;
        s_in_tdata = rand_word();
        s_in_tlast = 1'b0;
        m_out_tready = 1'b1;
        #1;
        step();
        s_in_tvalid = 1'b0;
        step();
        step();
        #1;
        chk("t31_busy_before", IN_W'(m_out_tvalid), IN_W'(1));
        rst = 1'b1;
        #1;
        chk("t31_async_valid", IN_W'(m_out_tvalid), '0);
        chk("t31_async_tdata", IN_W'(m_out_tdata), '0);
        chk("t31_async_ready", IN_W'(s_in_tready), IN_W'(1));
        step();
        step();
        rst = 1'b0;
        s_in_tvalid = 1'b1;
        s_in_tdata = {4{32'hAAAAAAAA}};
        s_in_tlast = 1'b1;
        #1;
        step();
        s_in_tvalid = 1'b0;
        #1;
        chk("t31_first_slice", IN_W'(m_out_tdata), IN_W'(32'hAAAAAAAA));
        chk("t31_first_not_last", IN_W'(m_out_tlast), '0);
        repeat (6) step();

        // Random valid/ready traffic against the scoreboard.
        acc = 0;
        cyc = 0;
        while (acc < NWORDS && cyc < 60000) begin
            s_in_tvalid = ($urandom_range(3) != 0);
            s_in_tdata = rand_word();
            s_in_tlast = ($urandom_range(3) == 0);
            m_out_tready = ($urandom_range(3) != 0);
            #1;
            if (s_in_tvalid && s_in_tready) acc++;
            step();
            cyc++;
        end
        chk("rand_words_accepted", IN_W'(acc), IN_W'(NWORDS));
        s_in_tvalid = 1'b0;
        m_out_tready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        chk("drain_empty", IN_W'(exp_q.size()), '0);
        chk("final_idle", IN_W'(m_out_tvalid), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
